core_row_gbus_sched: RTL and testbench

//  Sequences the global bus (gbus) of one head row of the core array (VNUM cores).
//  - Accepts burst commands: write words into selected cores' memories, or read words back.
//  - Write data arrives on a ready/valid input stream; read data leaves on a ready/valid output stream.
//  - Drives the row's one-hot gbus_wen/gbus_ren, shared address and write data; keeps one read outstanding.

---
 rtl/core_row_gbus_sched.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_core_row_gbus_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_row_gbus_sched.sv
// -----------------------------------------------------------------------------
// core_row_gbus_sched
// Global-bus sequencer for one head row of the core array.
//  - Burst commands write words into, or read words back from, the memories of
//    selected cores (columns) of the row.
//  - Write beats arrive on a ready/valid stream; read beats leave on one.
//  - Drives one-hot gbus_wen / gbus_ren with shared address and write data and
//    keeps at most one read outstanding on the bus.
// Traversal: enabled columns ascending (outer), addr = base..base+len (inner),
// address arithmetic wraps modulo 2^GBUS_ADDR.
// Optional feature macro: CORE_SCHED_RD_TIMEOUT_EN
//  - defined  : RD_WAIT aborts after RD_TIMEOUT cycles without gbus_rvalid[col],
//               sets sticky err and returns a zero beat; the burst continues.
//  - undefined: RD_WAIT waits indefinitely; err is tied low.
// -----------------------------------------------------------------------------
module core_row_gbus_sched #(
    parameter int VNUM      = 8,
    parameter int GBUS_DATA = 64,
    parameter int GBUS_ADDR = 12
`ifdef CORE_SCHED_RD_TIMEOUT_EN
   ,parameter int RD_TIMEOUT = 15
`endif
) (
    input  logic                     clk,
    input  logic                     rstn,
    // command
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic [GBUS_ADDR-1:0]     cmd_base_addr,
    input  logic [GBUS_ADDR-1:0]     cmd_len,
    input  logic [VNUM-1:0]          cmd_col_mask,
    // write beat stream
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [GBUS_DATA-1:0]     wr_data,
    // read beat stream
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [GBUS_DATA-1:0]     rd_data,
    output logic [$clog2(VNUM)-1:0]  rd_col,
    output logic                     rd_last,
    // row global bus
    output logic [GBUS_ADDR-1:0]     gbus_addr,
    output logic [VNUM-1:0]          gbus_wen,
    output logic [GBUS_DATA-1:0]     gbus_wdata,
    output logic [VNUM-1:0]          gbus_ren,
    input  logic [GBUS_DATA-1:0]     gbus_rdata,
    input  logic [VNUM-1:0]          gbus_rvalid,
    // status
    output logic                     busy,
    output logic                     err
);

    localparam int COL_W = $clog2(VNUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_OUT
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // latched command and traversal position
    logic [GBUS_ADDR-1:0]   r_base;
    logic [GBUS_ADDR-1:0]   r_len;
    logic [GBUS_ADDR-1:0]   r_off;
    logic [VNUM-1:0]        r_mask;
    logic [COL_W-1:0]       r_col;
    logic                   r_wr_done;

    // registered bus and read-beat outputs
    logic [GBUS_ADDR-1:0]   r_gbus_addr;
    logic [VNUM-1:0]        r_gbus_wen;
    logic [GBUS_DATA-1:0]   r_gbus_wdata;
    logic [VNUM-1:0]        r_gbus_ren;
    logic [GBUS_DATA-1:0]   r_rd_data;
    logic [COL_W-1:0]       r_rd_col;
    logic                   r_rd_last;

    // traversal helpers
    logic [COL_W-1:0]       w_first_col;
    logic [COL_W-1:0]       w_next_col;
    logic                   w_has_next;
    logic                   w_col_done;
    logic                   w_last;
    logic [COL_W-1:0]       w_adv_col;
    logic [GBUS_ADDR-1:0]   w_adv_off;
    logic                   w_wr_hs;
    logic                   w_rvalid_col;
    logic                   w_tmo;
    logic                   w_rd_capture;

    function automatic logic [VNUM-1:0] onehot(input logic [COL_W-1:0] col);
        return VNUM'(1) << col;
    endfunction

    // -------------------------------------------------------------------------
    // Simple status and handshake outputs
    // -------------------------------------------------------------------------
    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign wr_ready   = (r_state == S_WR) && !r_wr_done;
    assign rd_valid   = (r_state == S_RD_OUT);
    assign rd_data    = r_rd_data;
    assign rd_col     = r_rd_col;
    assign rd_last    = r_rd_last;
    assign gbus_addr  = r_gbus_addr;
    assign gbus_wen   = r_gbus_wen;
    assign gbus_wdata = r_gbus_wdata;
    assign gbus_ren   = r_gbus_ren;

    assign w_wr_hs      = wr_valid && wr_ready;
    assign w_rvalid_col = gbus_rvalid[r_col];
    assign w_rd_capture = (r_state == S_RD_WAIT) && (w_rvalid_col || w_tmo);

    // Position after the current beat: next word in this column, or the first
    // word of the next enabled column once this column's range is exhausted.
    assign w_col_done = (r_off == r_len);
    assign w_last     = w_col_done && !w_has_next;
    assign w_adv_col  = w_col_done ? w_next_col : r_col;
    assign w_adv_off  = w_col_done ? '0 : r_off + GBUS_ADDR'(1);

    // Lowest enabled column of a new command, and next enabled column above r_col
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        w_first_col = '0;
        w_next_col  = '0;
        w_has_next  = 1'b0;
        // Scan downward so the lowest qualifying index is written last and wins.
        for (int i = VNUM - 1; i >= 0; i--) begin
            if (cmd_col_mask[i]) begin
                w_first_col = COL_W'(i);
            end
            if (r_mask[i] && (i > int'(r_col))) begin
                w_has_next = 1'b1;
                w_next_col = COL_W'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // An all-zero mask is accepted but produces no bus activity.
                if (cmd_valid && (cmd_col_mask != '0)) begin
                    w_state_nxt = cmd_op ? S_RD_REQ : S_WR;
                end
            end
            S_WR: begin
                // Stay one extra cycle after the last beat so the final write is
                // driven while still busy.
                if (r_wr_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_REQ: begin
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_rd_capture) begin
                    w_state_nxt = S_RD_OUT;
                end
            end
            S_RD_OUT: begin
                if (rd_ready) begin
                    w_state_nxt = r_rd_last ? S_IDLE : S_RD_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: command latch, traversal position, bus and read-beat registers
    // -------------------------------------------------------------------------

    // Command/traversal registers and registered bus strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base       <= '0;
            r_len        <= '0;
            r_off        <= '0;
            r_mask       <= '0;
            r_col        <= '0;
            r_wr_done    <= 1'b0;
            r_gbus_addr  <= '0;
            r_gbus_wen   <= '0;
            r_gbus_wdata <= '0;
            r_gbus_ren   <= '0;
            r_rd_data    <= '0;
            r_rd_col     <= '0;
            r_rd_last    <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            r_gbus_wen <= '0;
            r_gbus_ren <= '0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_base    <= cmd_base_addr;
                        r_len     <= cmd_len;
                        r_mask    <= cmd_col_mask;
                        r_col     <= w_first_col;
                        r_off     <= '0;
                        r_wr_done <= 1'b0;
                        // First read request is issued in the RD_REQ cycle itself.
                        if (cmd_op && (cmd_col_mask != '0)) begin
                            r_gbus_ren  <= onehot(w_first_col);
                            r_gbus_addr <= cmd_base_addr;
                        end
                    end
                end
                S_WR: begin
                    if (w_wr_hs) begin
                        r_gbus_wen   <= onehot(r_col);
                        r_gbus_addr  <= r_base + r_off;
                        r_gbus_wdata <= wr_data;
                        r_col        <= w_adv_col;
                        r_off        <= w_adv_off;
                        if (w_last) begin
                            r_wr_done <= 1'b1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (w_rd_capture) begin
                        // A timed-out read presents a zero beat.
                        r_rd_data <= w_rvalid_col ? gbus_rdata : '0;
                        r_rd_col  <= r_col;
                        r_rd_last <= w_last;
                    end
                end
                S_RD_OUT: begin
                    if (rd_ready && !r_rd_last) begin
                        r_col       <= w_adv_col;
                        r_off       <= w_adv_off;
                        r_gbus_ren  <= onehot(w_adv_col);
                        r_gbus_addr <= r_base + w_adv_off;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CORE_SCHED_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Timeout fires on the RD_TIMEOUT-th RD_WAIT cycle still lacking rvalid.
    assign w_tmo = (r_state == S_RD_WAIT) && !w_rvalid_col &&
                   (r_tmo_cnt == TMO_W'(RD_TIMEOUT - 1));
    assign err   = r_err;

    // Read-wait cycle counter and sticky timeout flag (cleared by a new command)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == S_RD_WAIT) && !w_rd_capture) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if (cmd_valid && (r_state == S_IDLE)) begin
                r_err <= 1'b0;
            end else if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_core_row_gbus_sched.sv
// -----------------------------------------------------------------------------
// tb_core_row_gbus_sched
// Directed bench for core_row_gbus_sched. Expected bus transactions and read
// beats are pushed to scoreboard queues when a command is issued and popped as
// the DUT produces them. A small core responder answers each gbus_ren with
// rvalid two cycles later (and a stray rvalid on another column in between).
// Inputs change on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_core_row_gbus_sched;

    localparam int VNUM      = 8;
    localparam int GBUS_DATA = 64;
    localparam int GBUS_ADDR = 12;

    typedef struct {
        logic [VNUM-1:0]      wen;
        logic [VNUM-1:0]      ren;
        logic [GBUS_ADDR-1:0] addr;
        logic [GBUS_DATA-1:0] data;
    } bus_t;

    typedef struct {
        logic [GBUS_DATA-1:0] data;
        logic [2:0]           col;
        logic                 last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  cmd_valid, cmd_ready, cmd_op;
    logic [GBUS_ADDR-1:0]  cmd_base_addr, cmd_len;
    logic [VNUM-1:0]       cmd_col_mask;
    logic                  wr_valid, wr_ready;
    logic [GBUS_DATA-1:0]  wr_data;
    logic                  rd_valid, rd_ready, rd_last;
    logic [GBUS_DATA-1:0]  rd_data;
    logic [2:0]            rd_col;
    logic [GBUS_ADDR-1:0]  gbus_addr;
    logic [VNUM-1:0]       gbus_wen, gbus_ren, gbus_rvalid;
    logic [GBUS_DATA-1:0]  gbus_wdata, gbus_rdata;
    logic                  busy, err;

    core_row_gbus_sched #(
        .VNUM      (VNUM),
        .GBUS_DATA (GBUS_DATA),
        .GBUS_ADDR (GBUS_ADDR)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_base_addr (cmd_base_addr),
        .cmd_len       (cmd_len),
        .cmd_col_mask  (cmd_col_mask),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_col        (rd_col),
        .rd_last       (rd_last),
        .gbus_addr     (gbus_addr),
        .gbus_wen      (gbus_wen),
        .gbus_wdata    (gbus_wdata),
        .gbus_ren      (gbus_ren),
        .gbus_rdata    (gbus_rdata),
        .gbus_rvalid   (gbus_rvalid),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bus_t                 bus_q[$];
    beat_t                rd_q[$];
    logic [GBUS_DATA-1:0] wr_src[$];

    // core responder state
    logic                 resp_pend = 1'b0;
    int                   resp_cnt  = 0;
    int                   resp_col  = 0;
    logic [GBUS_ADDR-1:0] resp_addr = '0;
    int                   resp_skip = 0;

    // write timing bookkeeping
    int first_wen_cyc = -1;
    int last_wen_cyc  = -1;

    function automatic logic [GBUS_DATA-1:0] rdat(input int c, input logic [GBUS_ADDR-1:0] a);
        return 64'hA5C0_0000_0000_0000 | (64'(c) << 32) | 64'(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: settle handshakes due at the coming edge, then at the
    // falling edge feed the write stream, score the bus and run the responder.
    task automatic tick();
        logic  wr_hs;
        bus_t  e;
        beat_t b;
        logic [VNUM-1:0] noise;
        if (rd_valid && rd_ready) begin
            check("rd_q_nonempty", 64'(rd_q.size() != 0), 64'd1);
            if (rd_q.size() != 0) begin
                b = rd_q.pop_front();
                check("rd_data", rd_data, b.data);
                check("rd_col",  64'(rd_col), 64'(b.col));
                check("rd_last", 64'(rd_last), 64'(b.last));
            end
        end
        wr_hs = wr_valid && wr_ready;
        @(negedge clk);
        cyc++;
        if (wr_hs) begin
            void'(wr_src.pop_front());
            if (wr_src.size() != 0) begin
                wr_data = wr_src[0];
            end else begin
                wr_valid = 1'b0;
            end
        end
        if ((gbus_wen != '0) || (gbus_ren != '0)) begin
            check("wen_ren_exclusive", 64'((gbus_wen != '0) && (gbus_ren != '0)), 64'd0);
            check("bus_q_nonempty", 64'(bus_q.size() != 0), 64'd1);
            if (bus_q.size() != 0) begin
                e = bus_q.pop_front();
                check("gbus_wen",  64'(gbus_wen),  64'(e.wen));
                check("gbus_ren",  64'(gbus_ren),  64'(e.ren));
                check("gbus_addr", 64'(gbus_addr), 64'(e.addr));
                if (e.wen != '0) begin
                    check("gbus_wdata", gbus_wdata, e.data);
                end
            end
            if (gbus_wen != '0) begin
                if (first_wen_cyc < 0) first_wen_cyc = cyc;
                last_wen_cyc = cyc;
                if (wr_src.size() == 0) begin
                    check("wr_ready_after_last", 64'(wr_ready), 64'd0);
                end
            end
        end
        // responder: one-cycle rvalid pulse, stray rvalid on another column meanwhile
        gbus_rvalid = '0;
        gbus_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        if (resp_pend) begin
            if (resp_cnt == 0) begin
                gbus_rvalid[resp_col] = 1'b1;
                gbus_rdata = rdat(resp_col, resp_addr);
                resp_pend = 1'b0;
            end else begin
                resp_cnt--;
                noise = '0;
                noise[(resp_col + 1) % VNUM] = 1'b1;
                gbus_rvalid = noise;
            end
        end
        if (gbus_ren != '0) begin
            if (resp_skip > 0) begin
                resp_skip--;
            end else begin
                resp_pend = 1'b1;
                resp_cnt  = 1;
                resp_addr = gbus_addr;
                for (int i = 0; i < VNUM; i++) if (gbus_ren[i]) resp_col = i;
            end
        end
    endtask

    // Issue one command and push everything it should produce.
    task automatic issue(input logic op, input logic [GBUS_ADDR-1:0] base,
                         input logic [GBUS_ADDR-1:0] len, input logic [VNUM-1:0] mask,
                         input int zero_beats);
        int n;
        int k;
        bus_t e;
        beat_t b;
        logic [GBUS_ADDR-1:0] a;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        k = 0;
        for (int c = 0; c < VNUM; c++) begin
            if (mask[c]) begin
                for (int o = 0; o <= int'(len); o++) begin
                    a = base + GBUS_ADDR'(o);
                    e.wen  = op ? '0 : (VNUM'(1) << c);
                    e.ren  = op ? (VNUM'(1) << c) : '0;
                    e.addr = a;
                    e.data = {$urandom, $urandom};
                    bus_q.push_back(e);
                    if (!op) begin
                        wr_src.push_back(e.data);
                    end else begin
                        b.data = (k < zero_beats) ? '0 : rdat(c, a);
                        b.col  = 3'(c);
                        b.last = 1'b0;
                        rd_q.push_back(b);
                    end
                    k++;
                end
            end
        end
        if (op && (mask != '0)) begin
            b = rd_q.pop_back();
            b.last = 1'b1;
            rd_q.push_back(b);
        end
        cmd_valid     = 1'b1;
        cmd_op        = op;
        cmd_base_addr = base;
        cmd_len       = len;
        cmd_col_mask  = mask;
        if (wr_src.size() != 0) begin
            wr_valid = 1'b1;
            wr_data  = wr_src[0];
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget && !(!busy && bus_q.size() == 0 && rd_q.size() == 0 && wr_src.size() == 0)) begin
            tick();
            n++;
        end
        check("done_in_budget", 64'(n < budget), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"},  64'(cmd_ready),  64'd1);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_wr_ready"},   64'(wr_ready),   64'd0);
        check({tag, "_rd_valid"},   64'(rd_valid),   64'd0);
        check({tag, "_rd_data"},    rd_data,         64'd0);
        check({tag, "_rd_col"},     64'(rd_col),     64'd0);
        check({tag, "_rd_last"},    64'(rd_last),    64'd0);
        check({tag, "_gbus_addr"},  64'(gbus_addr),  64'd0);
        check({tag, "_gbus_wen"},   64'(gbus_wen),   64'd0);
        check({tag, "_gbus_wdata"}, gbus_wdata,      64'd0);
        check({tag, "_gbus_ren"},   64'(gbus_ren),   64'd0);
        check({tag, "_err"},        64'(err),        64'd0);
    endtask

    initial begin
        int n;
        rstn          = 1'b0;
        cmd_valid     = 1'b0;
        cmd_op        = 1'b0;
        cmd_base_addr = '0;
        cmd_len       = '0;
        cmd_col_mask  = '0;
        wr_valid      = 1'b0;
        wr_data       = '0;
        rd_ready      = 1'b1;
        gbus_rdata    = '0;
        gbus_rvalid   = '0;

        // reset state
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // 1: write mask 0000_0101, base 0x010, len 1 -> 4 back-to-back writes
        first_wen_cyc = -1;
        issue(1'b0, 12'h010, 12'd1, 8'b0000_0101, 0);
        wait_done(50);
        check("wr_back_to_back", 64'(last_wen_cyc - first_wen_cyc), 64'd3);

        // 2: read col 7, len 2, beat 0 stalled 5 cycles by rd_ready=0
        rd_ready = 1'b0;
        issue(1'b1, 12'h100, 12'd2, 8'b1000_0000, 0);
        n = 0;
        while (!rd_valid && n < 50) begin
            tick();
            n++;
        end
        check("rd_valid_seen", 64'(rd_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_rd_valid", 64'(rd_valid), 64'd1);
            check("stall_no_ren",   64'(gbus_ren), 64'd0);
            check("stall_rd_data",  rd_data, (rd_q.size() != 0) ? rd_q[0].data : 64'd0);
            tick();
        end
        rd_ready = 1'b1;
        wait_done(100);

        // read across two columns with address wrap
        issue(1'b1, 12'hFFE, 12'd2, 8'b0000_0110, 0);
        wait_done(100);

        // 3: write wrapping 0xFFF -> 0x000
        issue(1'b0, 12'hFFF, 12'd1, 8'b0000_0001, 0);
        wait_done(50);

        // 4: empty mask -> accepted, no bus activity, ready again next cycle
        issue(1'b0, 12'h055, 12'd3, 8'b0000_0000, 0);
        check("mask0_cmd_ready", 64'(cmd_ready), 64'd1);
        check("mask0_busy",      64'(busy),      64'd0);
        for (int i = 0; i < 3; i++) tick();

        // 5: reset during a 4-beat write after the first beat
        issue(1'b0, 12'h200, 12'd3, 8'b0000_1000, 0);
        n = 0;
        while (wr_src.size() > 3 && n < 50) begin
            tick();
            n++;
        end
        check("first_beat_taken", 64'(wr_src.size()), 64'd3);
        rstn = 1'b0;
        #1;
        check_idle_outputs("midreset");
        bus_q.delete();
        wr_src.delete();
        wr_valid = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        issue(1'b0, 12'h020, 12'd0, 8'b0011_0000, 0);
        wait_done(50);

`ifdef CORE_SCHED_RD_TIMEOUT_EN
        // 6: first read unanswered -> zero beat, err set, burst continues
        resp_skip = 1;
        issue(1'b1, 12'h300, 12'd1, 8'b0000_0010, 1);
        wait_done(200);
        check("tmo_err_set", 64'(err), 64'd1);
        issue(1'b0, 12'h000, 12'd0, 8'b0000_0000, 0);
        check("tmo_err_cleared", 64'(err), 64'd0);
`else
        check("err_low", 64'(err), 64'd0);
`endif

        check("bus_q_drained", 64'(bus_q.size()), 64'd0);
        check("rd_q_drained",  64'(rd_q.size()),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
